// File: rtl/keypad_matrix_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive on each scan tick,
// assembles a 16-position frame every four ticks and debounces press/release per frame.
module keypad_matrix_scanner #(
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_clk,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        PRESSED  = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       row_meta_q, row_sync_q;
    logic             scan_clk_q;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;
    logic [15:0]      frame_q, frame_d;
    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic             tick_s;
    logic             frame_eval_s;
    logic [15:0]      frame_full_s;
    logic [1:0]       n_low_s;
    logic [3:0]       hit_code_s;
    logic             single_s;
    logic             empty_s;
    logic [CNT_W-1:0] cnt_inc_s;

    // Scan tick, column sampling and frame classification
    always_comb begin
        tick_s       = scan_clk & ~scan_clk_q;
        frame_eval_s = tick_s && (col_idx_q == 2'd3);

        // Frame bits are 1 where the key is seen pressed (row pulled low).
        frame_full_s = frame_q;
        for (int r = 0; r < 4; r++) begin
            frame_full_s[4*r + int'(col_idx_q)] = ~row_sync_q[r];
        end

        n_low_s    = 2'd0;
        hit_code_s = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_full_s[i]) begin
                if (n_low_s != 2'd2) begin
                    n_low_s = n_low_s + 2'd1;
                end else begin
                    n_low_s = 2'd2;
                end
                hit_code_s = 4'(i);
            end else begin
                n_low_s = n_low_s;
            end
        end
        single_s  = (n_low_s == 2'd1);
        empty_s   = (n_low_s == 2'd0);
        cnt_inc_s = cnt_q + CNT_ONE;

        if (tick_s) begin
            col_idx_d = col_idx_q + 2'd1;
            col_d     = {col_q[2:0], col_q[3]};
            frame_d   = frame_eval_s ? 16'h0000 : frame_full_s;
        end else begin
            col_idx_d = col_idx_q;
            col_d     = col_q;
            frame_d   = frame_q;
        end
    end

    // Debounce FSM next-state, advancing only at frame evaluation
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        if (frame_eval_s) begin
            case (state_q)
                IDLE: begin
                    if (single_s) begin
                        state_d = PRESS_DB;
                        cand_d  = hit_code_s;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                PRESS_DB: begin
                    if (single_s && (hit_code_s == cand_q)) begin
                        if (cnt_inc_s == DB_LAST) begin
                            state_d     = PRESSED;
                            cnt_d       = '0;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc_s;
                        end
                    end else if (single_s) begin
                        cand_d = hit_code_s;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    // Multiple keys still count as "held" so ghosting cannot fake a release.
                    if (empty_s) begin
                        state_d = REL_DB;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                REL_DB: begin
                    if (empty_s) begin
                        if (cnt_inc_s == DB_LAST) begin
                            state_d    = IDLE;
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                        end else begin
                            cnt_d = cnt_inc_s;
                        end
                    end else begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // All state, synchronisers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            scan_clk_q  <= 1'b0;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            frame_q     <= 16'h0000;
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_meta_q  <= row;
            row_sync_q  <= row_meta_q;
            scan_clk_q  <= scan_clk;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            frame_q     <= frame_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a keypad model drives rows from the column drive,
// a frame-history reference model predicts accepted keys into a queue checked by a monitor.
module tb_keypad_matrix_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scan_clk = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed = 16'h0000;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          col_m = 0;
    logic [15:0] acc_m = 16'h0000;
    int          hist_m[$];
    bit          held_m = 1'b0;
    int          code_m = 0;
    int          exp_q[$];

    keypad_matrix_scanner #(.DEBOUNCE_FRAMES(4), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_clk  (scan_clk),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // A pressed key connects its row to its column; rows idle high
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && pressed[4*r + c]) row[r] = 1'b0;
    end

    // Monitor: every valid pulse must match the oldest predicted acceptance
    always @(negedge clk) begin
        if (key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got key_code=%0d, no pulse expected", key_code);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (key_code != 4'(e) || !key_held) begin
                    errors++;
                    $display("FAIL valid_code: got key_code=%0d held=%0b, expected %0d held=1", key_code, key_held, e);
                end
            end
        end
    end

    function automatic int classify(input logic [15:0] f);
        int idx;
        idx = -1;
        if ($countones(f) == 0) return -1;
        if ($countones(f) > 1) return 16;
        for (int i = 0; i < 16; i++) if (f[i]) idx = i;
        return idx;
    endfunction

    // Press accepted when the last 4 frames are the same single key; release when they are all empty
    task automatic model_tick(input logic [15:0] mask);
        for (int r = 0; r < 4; r++) acc_m[4*r + col_m] = mask[4*r + col_m];
        if (col_m == 3) begin
            hist_m.push_back(classify(acc_m));
            if (hist_m.size() > 4) void'(hist_m.pop_front());
            acc_m = 16'h0000;
            if (hist_m.size() == 4) begin
                bool_check: begin
                    bit same_single, all_empty;
                    same_single = (hist_m[0] >= 0) && (hist_m[0] < 16);
                    all_empty = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        if (hist_m[i] != hist_m[0]) same_single = 1'b0;
                        if (hist_m[i] != -1) all_empty = 1'b0;
                    end
                    if (!held_m && same_single) begin
                        held_m = 1'b1;
                        code_m = hist_m[0];
                        exp_q.push_back(hist_m[0]);
                    end else if (held_m && all_empty) begin
                        held_m = 1'b0;
                    end
                end
            end
        end
        col_m = (col_m + 1) % 4;
    endtask

    task automatic check_state(input string tag);
        logic [3:0] ec;
        ec = 4'hF;
        ec[col_m] = 1'b0;
        checks++;
        if (col !== ec) begin
            errors++;
            $display("FAIL %s col: got %b, expected %b", tag, col, ec);
        end
        checks++;
        if (key_held !== held_m) begin
            errors++;
            $display("FAIL %s key_held: got %b, expected %b", tag, key_held, held_m);
        end
        checks++;
        if (key_code !== 4'(code_m)) begin
            errors++;
            $display("FAIL %s key_code: got %0d, expected %0d", tag, key_code, code_m);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_valid: %0d predicted pulse(s) not seen, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // One scan period of 64 clk: keys settle in the low phase before the rising edge
    task automatic period(input logic [15:0] mask, input string tag);
        pressed = mask;
        repeat (16) @(negedge clk);
        scan_clk = 1'b1;
        model_tick(mask);
        repeat (32) @(negedge clk);
        scan_clk = 1'b0;
        repeat (16) @(negedge clk);
        check_state(tag);
    endtask

    task automatic frames(input logic [15:0] mask, input int n, input string tag);
        for (int i = 0; i < 4*n; i++) period(mask, tag);
    endtask

    task automatic model_reset();
        col_m  = 0;
        acc_m  = 16'h0000;
        hist_m.delete();
        held_m = 1'b0;
        code_m = 0;
        exp_q.delete();
    endtask

    localparam logic [15:0] K0  = 16'h0001;
    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K15 = 16'h8000;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (col !== 4'b1110 || key_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_col: got col=%b valid=%b, expected 1110/0", col, key_valid);
            end
        end
        check_state("reset");

        frames(K6, 6, "press6");
        frames(16'h0000, 5, "release6");

        for (int t = 0; t < 24; t++) period(((t / 3) % 2 == 0) ? K6 : 16'h0000, "bounce");
        frames(K6, 5, "stable6");
        frames(16'h0000, 5, "release6b");

        frames(K0 | K15, 10, "multi");
        frames(16'h0000, 2, "after_multi");

        frames(K6, 5, "press6c");
        frames(16'h0000, 5, "release6c");
        frames(K9, 5, "press9");
        frames(K6, 5, "switch6");
        frames(16'h0000, 5, "release_sw");

        frames(K6, 3, "pre_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        checks++;
        if (col !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL midreset: got col=%b code=%0d valid=%b held=%b, expected 1110/0/0/0",
                     col, key_code, key_valid, key_held);
        end
        frames(K6, 3, "post_reset_partial");
        frames(K6, 2, "post_reset_accept");
        frames(16'h0000, 5, "post_reset_release");

        begin
            logic [15:0] cur;
            cur = 16'h0000;
            for (int f = 0; f < 40; f++) begin
                int kind, a, b;
                kind = $urandom_range(0, 9);
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                if (kind >= 4 && kind <= 5) cur = 16'h0000;
                else if (kind >= 6 && kind <= 8) cur = 16'h0001 << a;
                else if (kind == 9) cur = (16'h0001 << a) | (16'h0001 << b);
                for (int p = 0; p < 4; p++)
                    period(($urandom_range(0, 7) == 0) ? 16'h0000 : cur, "random");
            end
        end
        frames(16'h0000, 5, "final_release");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL end_queue: %0d pulses outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
